// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier controller for the EX stage (MUL/MULI/MULA).
// Optional early termination on an exhausted multiplier: define MUL_EARLY_OUT_EN.
module mul_sequencer #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc_in,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(N + 1);

  if ((BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) ||
      (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("mul_sequencer: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mplier_nxt;
  logic             last_iter;

  // Partial products for the multiplier bits retired this cycle.
  always_comb begin
    acc_nxt = acc;
    for (int k = 0; k < int'(BITS_PER_CYCLE); k++) begin
      if (mplier[k]) acc_nxt = acc_nxt + (mcand << k);
    end
  end

  assign mplier_nxt = mplier >> BITS_PER_CYCLE;

`ifdef MUL_EARLY_OUT_EN
  assign last_iter = (count == CNT_W'(1)) || (mplier_nxt == '0);
`else
  assign last_iter = (count == CNT_W'(1));
`endif

  // Stall covers the accepting IDLE cycle combinationally, then all of RUN.
  assign stall = (state == S_RUN) || ((state == S_IDLE) && start && !flush);
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= acc_en ? acc_in : '0;
            count  <= CNT_W'(N);
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand << BITS_PER_CYCLE;
            mplier <= mplier_nxt;
            count  <= count - CNT_W'(1);
            if (last_iter) begin
              state  <= S_DONE;
              done   <= 1'b1;
              result <= acc_nxt;
            end
          end
        end
        S_DONE: begin
          // Same instruction still sits in EX; start is not re-sampled here.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle iterative shift-add multiplier controller for the EX stage.
- Services the MUL, MULI and MULA operations: latches operands, sequences the partial-product iterations and holds the pipeline stalled until the product is ready.
- Raises a one-cycle done pulse when the result is valid.
- Replaces the single-cycle multiply path. The ALU multiply result mux selects this block's result when the decoded AluOp is multiply.

Parameters:
- WIDTH, 32, operand and result width in bits.
- BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle. Must divide WIDTH; legal values 1, 2, 4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  EX stage holds a valid multiply op (AluOp==multiply). Held high while stalled.
- acc_en  input  1  MULA select (decoder AluOp2). Sampled with start.
- op_a  input  WIDTH  multiplicand.
- op_b  input  WIDTH  multiplier.
- acc_in  input  WIDTH  accumulate addend, used only when acc_en=1.
- flush  input  1  pipeline flush (branch/jump). Aborts the operation in progress.
- stall  output  1  freeze PC, IF/ID and ID/EX.
- busy  output  1  FSM not in IDLE.
- done  output  1  single-cycle pulse; result valid.
- result  output  WIDTH  low WIDTH bits of op_a*op_b (+acc_in).

Behaviour:
- Reset (sync, priority over everything): state=IDLE, stall=0, busy=0, done=0, result=0, internal registers cleared. Reset mid-RUN abandons the operation with no done pulse.
- N = WIDTH/BITS_PER_CYCLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and flush=0: latch op_a, op_b, and the addend (acc_in if acc_en, else 0); iteration count=N; go to RUN.
  - Combinational stall=1 in this same cycle.
- RUN:
  - Each cycle, add op_a shifted by the current bit position (masked per multiplier bit) for BITS_PER_CYCLE bits to the accumulator, shift the multiplier right, decrement count.
  - When count==1, next state is DONE.
  - stall=1, busy=1.
- DONE:
  - done=1 and result updated for exactly one cycle.
  - stall=0 so the instruction leaves EX at this edge; busy=1.
  - start is ignored in this state (it is the same instruction). Next state is IDLE.
- Latency: start accepted in cycle T; RUN occupies T+1..T+N; done in T+N+1. stall is high T..T+N and low at T+N+1. WIDTH=32 and BITS_PER_CYCLE=1 gives done 33 cycles after acceptance.
- Arithmetic:
  - All operations are modulo 2^WIDTH.
  - The low bits are identical for signed and unsigned operands, so no sign handling is needed.
  - Overflow is discarded silently.
  - MULA addend is added into the initial accumulator value.
- result holds its value after DONE until the next DONE or reset.
- flush:
  - In RUN or IDLE it forces IDLE the next cycle; no done pulse; result unchanged.
  - start and flush together in IDLE is not accepted.
  - flush in DONE has no effect: the completed result still pulses.
- Back-to-back multiplies: a start in the cycle after DONE (IDLE) is accepted normally. There is a minimum one-cycle gap between done pulses.

Optional Feature:
- Macro MUL_EARLY_OUT_EN.
- Defined: in RUN, if the multiplier remaining after this cycle's shift is zero, the next state is DONE regardless of count.
  - op_b=0 or op_b=1 gives done at T+2.
  - op_b=0x80000000 still takes the full N cycles.
- Undefined: fixed latency N+1 for all operands; the early-out logic is absent.

Test Plan (WIDTH=32, BITS_PER_CYCLE=1):
- Reset, then start with op_a=7, op_b=6, acc_en=0 at T:
  - stall high T..T+32.
  - done pulses only at T+33, with result=42.
  - Feature off.
- MULA with op_a=0xFFFFFFFF, op_b=2, acc_in=5, acc_en=1 -> result=0x00000003, showing wraparound.
- flush asserted at T+10 of an op_a=3, op_b=4 op:
  - IDLE at T+11, no done pulse, stall low from T+11, result holds its previous value.
- reset asserted at T+5 mid-RUN -> all outputs 0 next cycle; no done pulse thereafter.
- Back-to-back ops 0x10000*0x10000 then 5*5 with start re-asserted right after done:
  - Results 0x00000000 then 25.
  - Done pulses separated by 34 cycles.
- MUL_EARLY_OUT_EN defined, op_a=9, op_b=1 -> done at T+2, result=9. op_b=0x80000000 -> done at T+33, result=0x80000000.
